// File: rtl/divmod_pkg.sv
// Shared definitions for the sequential divider: FSM encoding, default width,
// and the two's-complement negate used on operands and results.
package divmod_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DEFAULT_WIDTH = 32;

  // Widest operand the negate helper supports; callers size-cast in and out.
  localparam int MAX_WIDTH = 128;

  // Truncating the result to N bits gives the correct N-bit two's-complement negate.
  function automatic logic [MAX_WIDTH-1:0] twos_neg(input logic [MAX_WIDTH-1:0] v);
    return ~v + MAX_WIDTH'(1);
  endfunction

endpackage

// File: rtl/divmod_seq_if.sv
// Request/response bundle between an arithmetic client (master) and the divider (slave).
interface divmod_seq_if
  import divmod_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             is_signed;
  logic             abort;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_zero;

  modport master (
    output in_valid, A, B, is_signed, abort, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_zero
  );

  modport slave (
    input  in_valid, A, B, is_signed, abort, out_ready,
    output in_ready, out_valid, quotient, remainder, div_zero
  );
endinterface

// File: rtl/divmod_step.sv
// One radix-2 restoring iteration on unsigned magnitudes: shift {rem,quo} left,
// try subtracting the divisor, keep the difference only when it stays non-negative.
module divmod_step
  import divmod_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;

  // rem < divisor on entry, so rem_sh < 2*divisor and bit WIDTH of trial is a true sign.
  assign rem_sh   = {rem, quo[WIDTH-1]};
  assign trial    = rem_sh - {1'b0, divisor};
  assign rem_next = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_next = {quo[WIDTH-2:0], ~trial[WIDTH]};

endmodule

// File: rtl/divmod_seq.sv
// Sequential signed/unsigned divider: one quotient bit per clock, sign fix-up
// cycle, registered results held in DONE until the consumer takes them.
module divmod_seq
  import divmod_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input logic         clk,
  input logic         resetn,
  divmod_seq_if.slave bus
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem, quo, divisor;
  logic [WIDTH-1:0] rem_step, quo_step;
  logic             neg_q, neg_r, dz;
  logic [WIDTH-1:0] q_out, r_out;
  logic             dz_out;

  logic             a_neg, b_neg, b_zero, last_iter;
  logic [WIDTH-1:0] abs_a, abs_b;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return WIDTH'(twos_neg(MAX_WIDTH'(v)));
  endfunction

  assign a_neg     = bus.is_signed & bus.A[WIDTH-1];
  assign b_neg     = bus.is_signed & bus.B[WIDTH-1];
  assign b_zero    = (bus.B == '0);
  assign abs_a     = a_neg ? neg_w(bus.A) : bus.A;
  assign abs_b     = b_neg ? neg_w(bus.B) : bus.B;
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  divmod_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (divisor),
    .rem_next (rem_step),
    .quo_next (quo_step)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the always blocks are evaluated.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // NOTE: next-state gets its default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    if (bus.abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.in_valid) state_nxt = b_zero ? FIX : CALC;
        CALC:    if (last_iter) state_nxt = FIX;
        FIX:     state_nxt = DONE;
        DONE:    if (bus.out_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt     <= '0;
      rem     <= '0;
      quo     <= '0;
      divisor <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      dz      <= 1'b0;
      q_out   <= '0;
      r_out   <= '0;
      dz_out  <= 1'b0;
    end else if (bus.abort) begin
      cnt     <= '0;
      rem     <= '0;
      quo     <= '0;
      divisor <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      dz      <= 1'b0;
      q_out   <= '0;
      r_out   <= '0;
      dz_out  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            cnt     <= '0;
            rem     <= '0;
            // On divide-by-zero quo carries the raw dividend straight to the remainder output.
            quo     <= b_zero ? bus.A : abs_a;
            divisor <= abs_b;
            neg_q   <= a_neg ^ b_neg;
            neg_r   <= a_neg;
            dz      <= b_zero;
          end
        end
        CALC: begin
          rem <= rem_step;
          quo <= quo_step;
          cnt <= cnt + CNT_W'(1);
        end
        FIX: begin
          if (dz) begin
            q_out  <= '1;
            r_out  <= quo;
            dz_out <= 1'b1;
          end else begin
            q_out  <= neg_q ? neg_w(quo) : quo;
            r_out  <= neg_r ? neg_w(rem) : rem;
            dz_out <= 1'b0;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            q_out  <= '0;
            r_out  <= '0;
            dz_out <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.quotient  = q_out;
  assign bus.remainder = r_out;
  assign bus.div_zero  = dz_out;

endmodule

// File: tb/tb_divmod_seq.sv
// Directed bench for divmod_seq: scoreboard of expected results pushed at accept
// time and popped when out_valid appears; a second instance covers WIDTH=2.
module tb_divmod_seq;
  import divmod_pkg::*;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } exp_t;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  int   tests_run = 0;
  int   failed    = 0;
  exp_t sb[$];

  divmod_seq_if #(.WIDTH(W)) bus ();
  divmod_seq_if #(.WIDTH(2)) bus2 ();

  divmod_seq #(.WIDTH(W)) dut  (.clk(clk), .resetn(resetn), .bus(bus));
  divmod_seq #(.WIDTH(2)) dut2 (.clk(clk), .resetn(resetn), .bus(bus2));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: unsigned / and % on magnitudes, then sign fix-up.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic         na, nb;
    logic [W-1:0] ma, mb, q, r;
    if (b == '0) return '{q: '1, r: a, dz: 1'b1};
    na = s & a[W-1];
    nb = s & b[W-1];
    ma = na ? W'(0) - a : a;
    mb = nb ? W'(0) - b : b;
    q  = ma / mb;
    r  = ma % mb;
    if (na ^ nb) q = W'(0) - q;
    if (na)      r = W'(0) - r;
    return '{q: q, r: r, dz: 1'b0};
  endfunction

  // Returns #1 after the accept edge; operands are then scrambled to prove they were latched.
  task automatic drive_accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    @(negedge clk);
    bus.A         = a;
    bus.B         = b;
    bus.is_signed = s;
    bus.in_valid  = 1'b1;
    check("in_ready_before_accept", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.A         = $urandom;
    bus.B         = $urandom;
    bus.is_signed = ~s;
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
    drive_accept(a, b, s);
    sb.push_back('{q: eq, r: er, dz: edz});
  endtask

  // Latency counts the accept cycle as cycle 1; ends on the negedge where out_valid is seen.
  task automatic wait_result(input int exp_lat);
    int   n = 0;
    exp_t e;
    @(negedge clk);
    while (!bus.out_valid && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("latency", 64'(n + 1), 64'(exp_lat));
    check("sb_outstanding", 64'(sb.size()), 64'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("quotient", 64'(bus.quotient), 64'(e.q));
      check("remainder", 64'(bus.remainder), 64'(e.r));
      check("div_zero", 64'(bus.div_zero), 64'(e.dz));
    end
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("idle_out_valid", 64'(bus.out_valid), 64'd0);
    check("idle_quotient", 64'(bus.quotient), 64'd0);
    check("idle_in_ready", 64'(bus.in_ready), 64'd1);
  endtask

  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                    input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
    issue(a, b, s, eq, er, edz);
    wait_result(edz ? 2 : W + 2);
    consume();
  endtask

  task automatic watch_no_valid(input string tag);
    logic seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    check(tag, 64'(seen), 64'd0);
  endtask

  task automatic run2(input logic [1:0] a, input logic [1:0] b, input logic s,
                      input logic [1:0] eq, input logic [1:0] er);
    int n = 0;
    @(negedge clk);
    bus2.A = a; bus2.B = b; bus2.is_signed = s; bus2.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus2.in_valid = 1'b0;
    @(negedge clk);
    while (!bus2.out_valid && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("w2_latency", 64'(n + 1), 64'd4);
    check("w2_quotient", 64'(bus2.quotient), 64'(eq));
    check("w2_remainder", 64'(bus2.remainder), 64'(er));
    bus2.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus2.out_ready = 1'b0;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    logic [W-1:0] ra, rb;

    bus.in_valid  = 1'b0; bus.A = '0; bus.B = '0; bus.is_signed = 1'b0;
    bus.abort     = 1'b0; bus.out_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.A = '0; bus2.B = '0; bus2.is_signed = 1'b0;
    bus2.abort    = 1'b0; bus2.out_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_quotient", 64'(bus.quotient), 64'd0);
    check("rst_remainder", 64'(bus.remainder), 64'd0);
    check("rst_div_zero", 64'(bus.div_zero), 64'd0);
    resetn = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Basic unsigned and signed division
    op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
    op(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    op(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0);

    // Divide by zero in both modes
    op(32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 1'b1);
    op(32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd5, 1'b1);

    // Signed overflow and unsigned extremes
    op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0);
    op(32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0);

    // Backpressure: result held, no new request taken while DONE
    issue(32'd1000, 32'd3, 1'b0, 32'd333, 32'd1, 1'b0);
    wait_result(W + 2);
    bus.in_valid = 1'b1; bus.A = 32'd123; bus.B = 32'd4;
    repeat (10) begin
      @(negedge clk);
      check("bp_out_valid", 64'(bus.out_valid), 64'd1);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      check("bp_quotient", 64'(bus.quotient), 64'd333);
      check("bp_remainder", 64'(bus.remainder), 64'd1);
    end
    bus.in_valid = 1'b0;
    consume();

    // Abort on the fifth CALC cycle drops the operation
    drive_accept(32'd50, 32'd5, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    @(negedge clk);
    check("abort_in_ready", 64'(bus.in_ready), 64'd1);
    check("abort_out_valid", 64'(bus.out_valid), 64'd0);
    watch_no_valid("abort_no_valid");
    op(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0);

    // Reset asserted mid-CALC
    drive_accept(32'd77, 32'd4, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_quotient", 64'(bus.quotient), 64'd0);
    check("midrst_remainder", 64'(bus.remainder), 64'd0);
    check("midrst_div_zero", 64'(bus.div_zero), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    watch_no_valid("midrst_no_valid");

    // Mixed operands checked against the reference model
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom >> (i * 5);
      e  = model(ra, rb, i[0]);
      op(ra, rb, i[0], e.q, e.r, e.dz);
    end

    // WIDTH=2 instance: counter must stop after two CALC cycles
    run2(2'd3, 2'd1, 1'b0, 2'd3, 2'd0);
    run2(2'b10, 2'b11, 1'b1, 2'b10, 2'd0);
    run2(2'd3, 2'd2, 1'b0, 2'd1, 2'd1);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
